// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver with a single-word TX buffer returned on MISO.
// All SPI pins are resynchronised into clk; SCK edges are found by comparing against a delayed copy.
module spi_slave_rx #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_sck,
    input  logic          i_cs,
    input  logic          i_mosi,
    input  logic          i_dc,
    input  logic [DW-1:0] i_tx_data,
    input  logic          i_tx_load,
    output logic          o_miso,
    output logic [DW-1:0] o_data,
    output logic          o_dc,
    output logic          o_valid,
    output logic          o_frame_err,
    output logic          o_tx_empty
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;
    // Bit order {dc, mosi, cs, sck}: the idle bus levels.
    localparam logic [3:0] SYNC_RST = 4'b1110;

    logic [3:0] async_in;
    logic [3:0] sync_bits;

    assign async_in = {i_dc, i_mosi, i_cs, i_sck};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= SYNC_RST[gi];
                    sync_reg <= SYNC_RST[gi];
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic sck_s, cs_s, mosi_s, dc_s;
    assign sck_s  = sync_bits[0];
    assign cs_s   = sync_bits[1];
    assign mosi_s = sync_bits[2];
    assign dc_s   = sync_bits[3];

    logic [0:0]    state_reg;
    logic          sck_d_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic [DW-1:0] rx_shift_reg;
    logic [DW-1:0] tx_shift_reg;
    logic [DW-1:0] tx_buf_reg;
    logic          tx_empty_reg;
    logic          dc_cap_reg;
    logic          done_reg;
    logic          valid_pend_reg;
    logic          reload_pend_reg;

    logic          start, stop, rise_act, fall_act, last_bit, reload;
    logic [DW-1:0] tx_fill;

    always_comb begin
        start    = (state_reg == IDLE) && !cs_s;
        stop     = (state_reg == ACTIVE) && cs_s;
        rise_act = (state_reg == ACTIVE) && !cs_s && sck_s && !sck_d_reg;
        fall_act = (state_reg == ACTIVE) && !cs_s && !sck_s && sck_d_reg;
        last_bit = (bit_cnt_reg == CW'(DW - 1));
        reload   = start || (fall_act && reload_pend_reg);
        tx_fill  = tx_empty_reg ? {DW{1'b1}} : tx_buf_reg;
    end

    // Word completion runs through done -> o_data -> o_valid so o_valid lands
    // four clk edges after the edge that first registered the final SCK high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            sck_d_reg       <= 1'b0;
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
            tx_shift_reg    <= {DW{1'b1}};
            tx_buf_reg      <= '0;
            tx_empty_reg    <= 1'b1;
            dc_cap_reg      <= 1'b1;
            done_reg        <= 1'b0;
            valid_pend_reg  <= 1'b0;
            reload_pend_reg <= 1'b0;
            o_data          <= '0;
            o_dc            <= 1'b1;
            o_valid         <= 1'b0;
            o_frame_err     <= 1'b0;
        end else begin
            sck_d_reg      <= sck_s;
            done_reg       <= 1'b0;
            valid_pend_reg <= done_reg;
            o_valid        <= valid_pend_reg;
            o_frame_err    <= 1'b0;

            if (done_reg) begin
                o_data <= rx_shift_reg;
                o_dc   <= dc_cap_reg;
            end

            if (start) begin
                state_reg       <= ACTIVE;
                bit_cnt_reg     <= '0;
                reload_pend_reg <= 1'b0;
            end else if (stop) begin
                state_reg <= IDLE;
                if (bit_cnt_reg != '0) begin
                    o_frame_err <= 1'b1;
                end
            end else if (rise_act) begin
                rx_shift_reg <= {rx_shift_reg[DW-2:0], mosi_s};
                if (last_bit) begin
                    bit_cnt_reg     <= '0;
                    done_reg        <= 1'b1;
                    dc_cap_reg      <= dc_s;
                    reload_pend_reg <= 1'b1;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                end
            end else if (fall_act) begin
                reload_pend_reg <= 1'b0;
            end

            if (reload) begin
                tx_shift_reg <= tx_fill;
            end else if (fall_act) begin
                tx_shift_reg <= {tx_shift_reg[DW-2:0], 1'b1};
            end

            // A load wins the empty flag but the reload above used the old buffer.
            if (i_tx_load) begin
                tx_buf_reg   <= i_tx_data;
                tx_empty_reg <= 1'b0;
            end else if (reload) begin
                tx_empty_reg <= 1'b1;
            end
        end
    end

    assign o_miso     = (state_reg == ACTIVE) ? tx_shift_reg[DW-1] : 1'b1;
    assign o_tx_empty = tx_empty_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed SPI frames, received words checked by a scoreboard monitor.
module tb_spi_slave_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sck, cs, mosi, dc;
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic          miso;
    logic [DW-1:0] data;
    logic          dco, valid, frame_err, tx_empty;

    spi_slave_rx #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (sck),
        .i_cs       (cs),
        .i_mosi     (mosi),
        .i_dc       (dc),
        .i_tx_data  (tx_data),
        .i_tx_load  (tx_load),
        .o_miso     (miso),
        .o_data     (data),
        .o_dc       (dco),
        .o_valid    (valid),
        .o_frame_err(frame_err),
        .o_tx_empty (tx_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int exp_ferr = 0;
    logic [8:0] exp_q[$];
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the expected {dc, data} whenever the DUT presents a word.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            if (valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid actual data=%h dc=%b required no word", data, dco);
                end else begin
                    e = exp_q.pop_front();
                    if ({dco, data} !== e) begin
                        failures++;
                        $display("FAIL word actual dc=%b data=%h required dc=%b data=%h",
                                 dco, data, e[8], e[7:0]);
                    end
                end
                checks++;
                if (cyc - last_rise_cyc != 5) begin
                    failures++;
                    $display("FAIL valid_latency actual=%0d required=5", cyc - last_rise_cyc);
                end
                checks++;
                if (prev_valid) begin
                    failures++;
                    $display("FAIL valid_width actual=2+ cycles required=1");
                end
            end
            if (frame_err) begin
                checks++;
                if (exp_ferr == 0 || prev_ferr) begin
                    failures++;
                    $display("FAIL unexpected_frame_err actual=1 required=0");
                end else begin
                    exp_ferr--;
                end
            end
        end
        prev_valid = valid;
        prev_ferr  = frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        wait_clk(8);
    endtask

    // Master side of one word: MOSI set mid-low, MISO sampled as SCK rises.
    task automatic spi_byte(input logic [7:0] tx, input logic dcv, input int nbits,
                            input logic load_at_end, input logic [7:0] load_val,
                            output logic [7:0] rx);
        logic [7:0] r;
        r  = 8'h00;
        dc = dcv;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(4);
            sck = 1'b1;
            r = {r[6:0], miso};
            if (i == 7) last_rise_cyc = cyc;
            wait_clk(4);
            sck = 1'b0;
            if (i == 7 && load_at_end) begin
                wait_clk(2);
                tx_data = load_val;
                tx_load = 1'b1;
                wait_clk(1);
                tx_load = 1'b0;
                check("tx_empty_after_reload_load", {31'b0, tx_empty}, 32'd0);
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
        end
        rx = r;
    endtask

    task automatic check_reset_values();
        check("rst_data", {24'b0, data}, 32'h0);
        check("rst_dc", {31'b0, dco}, 32'd1);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_miso", {31'b0, miso}, 32'd1);
        check("rst_tx_empty", {31'b0, tx_empty}, 32'd1);
    endtask

    logic [7:0] rx;
    logic [7:0] seq[3];

    initial begin
        rst = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b1; dc = 1'b1;
        tx_data = '0; tx_load = 1'b0;
        wait_clk(3);
        check_reset_values();
        rst = 1'b1;
        wait_clk(4);

        // Single command word
        exp_q.push_back({1'b0, 8'h2A});
        frame_start();
        spi_byte(8'h2A, 1'b0, 8, 1'b0, 8'h00, rx);
        check("t1_miso", {24'b0, rx}, 32'hFF);
        frame_end();
        check("t1_data", {24'b0, data}, 32'h2A);
        check("t1_dc", {31'b0, dco}, 32'd0);

        // Three data words in one frame
        seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56;
        frame_start();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b1, seq[k]});
            spi_byte(seq[k], 1'b1, 8, 1'b0, 8'h00, rx);
            check("t2_miso", {24'b0, rx}, 32'hFF);
        end
        frame_end();
        check("t2_data", {24'b0, data}, 32'h56);

        // Partial word aborted by CS, then a clean word
        frame_start();
        spi_byte(8'hFF, 1'b1, 5, 1'b0, 8'h00, rx);
        exp_ferr = 1;
        frame_end();
        check("t3_frame_err_seen", exp_ferr, 0);
        check("t3_data_held", {24'b0, data}, 32'h56);
        exp_q.push_back({1'b1, 8'h3C});
        frame_start();
        spi_byte(8'h3C, 1'b1, 8, 1'b0, 8'h00, rx);
        frame_end();

        // Buffered TX word returned, then ones
        tx_data = 8'hA5; tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        check("t4_tx_empty_loaded", {31'b0, tx_empty}, 32'd0);
        frame_start();
        check("t4_tx_empty_at_cs", {31'b0, tx_empty}, 32'd1);
        exp_q.push_back({1'b1, 8'h00});
        spi_byte(8'h00, 1'b1, 8, 1'b0, 8'h00, rx);
        check("t4_miso_w0", {24'b0, rx}, 32'hA5);
        exp_q.push_back({1'b1, 8'h11});
        spi_byte(8'h11, 1'b1, 8, 1'b0, 8'h00, rx);
        check("t4_miso_w1", {24'b0, rx}, 32'hFF);
        frame_end();

        // Load coinciding with the post-word reload
        frame_start();
        exp_q.push_back({1'b0, 8'hC3});
        spi_byte(8'hC3, 1'b0, 8, 1'b1, 8'h55, rx);
        check("t5_miso_w0", {24'b0, rx}, 32'hFF);
        exp_q.push_back({1'b0, 8'h5A});
        spi_byte(8'h5A, 1'b0, 8, 1'b0, 8'h00, rx);
        check("t5_miso_w1", {24'b0, rx}, 32'hFF);
        exp_q.push_back({1'b0, 8'hA5});
        spi_byte(8'hA5, 1'b0, 8, 1'b0, 8'h00, rx);
        check("t5_miso_w2", {24'b0, rx}, 32'h55);
        frame_end();
        check("t5_tx_empty_end", {31'b0, tx_empty}, 32'd1);

        // Reset in the middle of a word
        frame_start();
        tx_data = 8'h77; tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        check("t6_tx_empty_loaded", {31'b0, tx_empty}, 32'd0);
        spi_byte(8'hF0, 1'b1, 4, 1'b0, 8'h00, rx);
        rst = 1'b0;
        wait_clk(1);
        check_reset_values();
        cs = 1'b1;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(6);
        exp_q.push_back({1'b1, 8'h81});
        frame_start();
        spi_byte(8'h81, 1'b1, 8, 1'b0, 8'h00, rx);
        frame_end();
        check("t6_data", {24'b0, data}, 32'h81);

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) wait_clk(1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_err_all_seen", exp_ferr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
